scoreboard_stall_unit: RTL and testbench
========================================

# scoreboard_stall_unit

Parametrised hazard and stall controller for the five-stage pipeline. It replaces opcode-pair hazard matching with a per-register pending-write scoreboard, so multi-cycle units (load, multiplier, iterative divider) are handled uniformly. The block sits beside the datapath and drives the load and flush controls of the PC and all four pipeline registers. It also keeps saturating performance counters for stall and freeze cycles.

## Interface
Parameters:
- NUM_REGS, 32: architectural registers; RID_W = $clog2(NUM_REGS).
- LAT_W, 4: width of each countdown entry; all-ones is reserved as DIV_PENDING.
- MUL_LAT, 3: cycles from a multiply entering EX until its result is forwardable. Legal range is 1 to 2^LAT_W-2.
- PERF_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- instr_mem_resp  in  1  I-cache has returned the fetched word.
- data_mem_resp  in  1  D-cache response.
- mem_access  in  1  the instruction in EX/MEM reads or writes memory.
- dec_valid  in  1  decode holds a real instruction.
- dec_rs1_id, dec_rs2_id  in  RID_W  source register ids.
- dec_use_rs1, dec_use_rs2  in  1  the corresponding source is actually read.
- dec_early  in  1  the consumer needs its operands at ID/EX input: branch, slt/sltu, jalr.
- dec_rd_id  in  RID_W  destination register id.
- dec_wr_en  in  1  the instruction writes rd.
- dec_class  in  3  fu_class_t: FU_ALU, FU_LOAD, FU_MUL, FU_DIV.
- dec_redirect  in  1  taken branch, jal or jalr resolved in decode.
- div_done  in  1  one-cycle pulse: divider result is on writeback.
- div_rd_id  in  RID_W  destination of the completing divide.
- load_pc, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1  register enables.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  bubble insertion.
- div_busy  out  1  a divide is in flight.
- stall_cycles, freeze_cycles  out  PERF_W  saturating counters.

## Operation
- **Scoreboard.** There is one cnt[r] per register; cnt[0] is hardwired to 0.
- **Issue.** An issue is dec_valid & ~hazard & ~freeze. On issue with dec_wr_en and rd≠0, cnt[rd] is loaded with L:
  - FU_ALU: L = 1.
  - FU_LOAD: L = 2.
  - FU_MUL: L = MUL_LAT.
  - FU_DIV: L = DIV_PENDING, and div_busy is set.
- **Countdown.** Every non-frozen cycle, each cnt that is nonzero and not DIV_PENDING decrements by 1. The entry written by an issue takes the new value instead of decrementing.
- **Divide completion.** On div_done, cnt[div_rd_id] ← 0 and div_busy is cleared. div_done is honoured even during freeze.
- **RAW hazard.** A used source s is a hazard when cnt[s] > (dec_early ? 0 : 1).
- **Structural hazard.** dec_class==FU_DIV while div_busy is a hazard. If div_done arrives in the same cycle, the stall still occurs (registered view).
- **WAW hazard.** dec_wr_en with cnt[rd]==DIV_PENDING is a hazard.
- **Default outputs.** All loads are 1 and all flushes are 0.
- **Controls, highest priority first:**
  1. Freeze, when mem_access & ~data_mem_resp: all five loads 0 and all flushes 0. Counters hold, and freeze_cycles increments.
  2. Hazard, when dec_valid: load_pc=0, if_id_load=0, id_ex_flush=1. stall_cycles increments. dec_redirect is ignored.
  3. Redirect, when dec_redirect & dec_valid: if_id_flush=1.
  4. I-cache miss, when ~instr_mem_resp: load_pc=0, if_id_flush=1. This combines with rule 3.
- **Performance counters** saturate at all-ones.

## Timing
- **Reset** (asynchronous, rst=0):
  - All cnt, div_busy and both perf counters are 0.
  - The control outputs are combinational. With instr_mem_resp=1 and mem_access=0 they read all loads 1 and all flushes 0.
- **Stall decisions** are combinational from the registered scoreboard and the current inputs, with zero-cycle latency. Scoreboard updates are visible the following cycle.
- **Stall lengths behind an immediately preceding producer:**
  - ALU: 0 cycles for a normal consumer, 1 for an early consumer.
  - LOAD: 1 cycle normal, 2 early.
  - MUL: MUL_LAT-1 cycles normal, MUL_LAT early.
- **Reset mid-divide** clears div_busy and DIV_PENDING at once. A late div_done after reset is harmless and simply writes 0.
- **Issue with div_done to the same rd:** the issue load wins.

## Structure
- Package rv32i_types gains:
  - fu_class_t.
  - The constants LAT_ALU=1, LAT_LOAD=2 and DIV_PENDING='1 (LAT_W-sized).
- Sub-module sb_countdown: one scoreboard entry holding load, decrement, clear-on-div_done and hold-on-freeze. It is instantiated NUM_REGS-1 times in a generate loop.
- The hazard check, the priority mux and the perf counters live in the top module.

## Test plan
- **ALU then early consumer.** Issue ALU x5, then beq reading x5 → exactly one stall cycle (id_ex_flush=1, load_pc=0), then issue.
- **LOAD then consumers.**
  - lw x7, then add using x7 → one stall.
  - With dec_early set, the consumer stalls two cycles instead.
  - With rd=x0 → no stall.
- **MUL with MUL_LAT=3.** mul x3, then an early consumer → 3 stalls. A normal consumer → 2 stalls.
- **Divide.**
  - Issue div x9, then a consumer of x9 → stall until div_done; issue occurs the cycle after div_done.
  - A second div during div_busy stalls.
  - An addi x9 during DIV_PENDING stalls (WAW).
- **Freeze.** A D-cache miss for 4 cycles while cnt[x4]=2 → all loads 0 for 4 cycles, cnt[x4] is still 2 afterwards, and freeze_cycles=4.
- **Priority and reset.**
  - Hazard plus dec_redirect → redirect suppressed.
  - Redirect plus I-miss → if_id_flush=1, load_pc=0.
  - Assert rst low during DIV_PENDING → div_busy=0 and all loads 1 immediately.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared pipeline types: functional-unit classes and scoreboard latencies
package rv32i_types;

    typedef enum logic [2:0] {
        FU_ALU  = 3'd0,
        FU_LOAD = 3'd1,
        FU_MUL  = 3'd2,
        FU_DIV  = 3'd3
    } fu_class_t;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    // Truncate to the entry width at the point of use; all-ones at any width.
    localparam logic [31:0] DIV_PENDING = '1;

endpackage

// File: rtl/sb_countdown.sv
// rtl/sb_countdown.sv - one scoreboard entry: load, countdown, divide clear, freeze hold
module sb_countdown
    import rv32i_types::*;
#(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    input  logic             div_clr_i,
    input  logic             freeze_i,
    output logic [LAT_W-1:0] cnt_o
);

    localparam logic [LAT_W-1:0] DIV_PEND = DIV_PENDING[LAT_W-1:0];

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    // A new issue beats a completing divide to the same register.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (div_clr_i) begin
            cnt_d = '0;
        end else if (!freeze_i && cnt_q != '0 && cnt_q != DIV_PEND) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/scoreboard_stall_unit.sv
// rtl/scoreboard_stall_unit.sv - scoreboard-based hazard detection and pipeline stall/flush control
module scoreboard_stall_unit
    import rv32i_types::*;
#(
    parameter int NUM_REGS = 32,
    parameter int RID_W    = $clog2(NUM_REGS),
    parameter int LAT_W    = 4,
    parameter int MUL_LAT  = 3,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_mem_resp,
    input  logic              data_mem_resp,
    input  logic              mem_access,
    input  logic              dec_valid,
    input  logic [RID_W-1:0]  dec_rs1_id,
    input  logic [RID_W-1:0]  dec_rs2_id,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic              dec_early,
    input  logic [RID_W-1:0]  dec_rd_id,
    input  logic              dec_wr_en,
    input  fu_class_t         dec_class,
    input  logic              dec_redirect,
    input  logic              div_done,
    input  logic [RID_W-1:0]  div_rd_id,
    output logic              load_pc,
    output logic              if_id_load,
    output logic              id_ex_load,
    output logic              ex_mem_load,
    output logic              mem_wb_load,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              div_busy,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] freeze_cycles
);

    localparam logic [LAT_W-1:0] DIV_PEND = DIV_PENDING[LAT_W-1:0];

    logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
    logic                           freeze;
    logic                           hazard;
    logic                           issue;
    logic                           raw1, raw2, struct_haz, waw_haz;
    logic [LAT_W-1:0]               raw_thresh;
    logic [LAT_W-1:0]               lat_val;
    logic                           div_busy_q, div_busy_d;
    logic [PERF_W-1:0]              stall_q, stall_d;
    logic [PERF_W-1:0]              freeze_q, freeze_d;

    assign freeze = mem_access & ~data_mem_resp;

    assign cnt[0] = '0;
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_countdown #(
            .LAT_W(LAT_W)
        ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .load_i    (issue & dec_wr_en & (dec_rd_id == RID_W'(r))),
            .load_val_i(lat_val),
            .div_clr_i (div_done & (div_rd_id == RID_W'(r))),
            .freeze_i  (freeze),
            .cnt_o     (cnt[r])
        );
    end

    always_comb begin
        lat_val = LAT_W'(LAT_ALU);
        unique case (dec_class)
            FU_LOAD: lat_val = LAT_W'(LAT_LOAD);
            FU_MUL:  lat_val = LAT_W'(MUL_LAT);
            FU_DIV:  lat_val = DIV_PEND;
            default: lat_val = LAT_W'(LAT_ALU);
        endcase
    end

    // Early consumers read operands before the EX forwarding point, so they need a fully drained entry.
    assign raw_thresh = dec_early ? '0 : LAT_W'(1);
    assign raw1       = dec_use_rs1 & (cnt[dec_rs1_id] > raw_thresh);
    assign raw2       = dec_use_rs2 & (cnt[dec_rs2_id] > raw_thresh);
    assign struct_haz = (dec_class == FU_DIV) & div_busy_q;
    assign waw_haz    = dec_wr_en & (cnt[dec_rd_id] == DIV_PEND);
    assign hazard     = dec_valid & (raw1 | raw2 | struct_haz | waw_haz);
    assign issue      = dec_valid & ~hazard & ~freeze;

    always_comb begin
        load_pc      = 1'b1;
        if_id_load   = 1'b1;
        id_ex_load   = 1'b1;
        ex_mem_load  = 1'b1;
        mem_wb_load  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (freeze) begin
            load_pc     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_load  = 1'b0;
            ex_mem_load = 1'b0;
            mem_wb_load = 1'b0;
        end else if (hazard) begin
            load_pc     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_flush = 1'b1;
        end else begin
            if (dec_redirect && dec_valid) begin
                if_id_flush = 1'b1;
            end
            if (!instr_mem_resp) begin
                load_pc     = 1'b0;
                if_id_flush = 1'b1;
            end
        end
    end

    always_comb begin
        div_busy_d = div_busy_q;
        if (issue && dec_class == FU_DIV) begin
            div_busy_d = 1'b1;
        end else if (div_done) begin
            div_busy_d = 1'b0;
        end
    end

    always_comb begin
        stall_d  = stall_q;
        freeze_d = freeze_q;
        if (freeze && !(&freeze_q)) begin
            freeze_d = freeze_q + PERF_W'(1);
        end
        if (!freeze && hazard && !(&stall_q)) begin
            stall_d = stall_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_busy_q <= 1'b0;
            stall_q    <= '0;
            freeze_q   <= '0;
        end else begin
            div_busy_q <= div_busy_d;
            stall_q    <= stall_d;
            freeze_q   <= freeze_d;
        end
    end

    assign div_busy      = div_busy_q;
    assign stall_cycles  = stall_q;
    assign freeze_cycles = freeze_q;

endmodule

// File: tb/tb_scoreboard_stall_unit.sv
// tb/tb_scoreboard_stall_unit.sv - directed self-checking bench for scoreboard_stall_unit
module tb_scoreboard_stall_unit;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_mem_resp, data_mem_resp, mem_access;
    logic        dec_valid, dec_use_rs1, dec_use_rs2, dec_early, dec_wr_en, dec_redirect;
    logic [4:0]  dec_rs1_id, dec_rs2_id, dec_rd_id, div_rd_id;
    fu_class_t   dec_class;
    logic        div_done;
    logic        load_pc, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        div_busy;
    logic [31:0] stall_cycles, freeze_cycles;

    int tests = 0;
    int fails = 0;

    // {load_pc, if_id, id_ex, ex_mem, mem_wb loads, if_id, id_ex, ex_mem, mem_wb flushes}
    localparam logic [8:0] NORM   = 9'b11111_0000;
    localparam logic [8:0] STALL  = 9'b00111_0100;
    localparam logic [8:0] FRZ    = 9'b00000_0000;
    localparam logic [8:0] REDIR  = 9'b11111_1000;
    localparam logic [8:0] IMISS  = 9'b01111_1000;

    logic [8:0] ctl;
    assign ctl = {load_pc, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    scoreboard_stall_unit dut (
        .clk           (clk),
        .rst           (rst),
        .instr_mem_resp(instr_mem_resp),
        .data_mem_resp (data_mem_resp),
        .mem_access    (mem_access),
        .dec_valid     (dec_valid),
        .dec_rs1_id    (dec_rs1_id),
        .dec_rs2_id    (dec_rs2_id),
        .dec_use_rs1   (dec_use_rs1),
        .dec_use_rs2   (dec_use_rs2),
        .dec_early     (dec_early),
        .dec_rd_id     (dec_rd_id),
        .dec_wr_en     (dec_wr_en),
        .dec_class     (dec_class),
        .dec_redirect  (dec_redirect),
        .div_done      (div_done),
        .div_rd_id     (div_rd_id),
        .load_pc       (load_pc),
        .if_id_load    (if_id_load),
        .id_ex_load    (id_ex_load),
        .ex_mem_load   (ex_mem_load),
        .mem_wb_load   (mem_wb_load),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_flush  (ex_mem_flush),
        .mem_wb_flush  (mem_wb_flush),
        .div_busy      (div_busy),
        .stall_cycles  (stall_cycles),
        .freeze_cycles (freeze_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic early,
                         input logic [4:0] rd, input logic wr, input fu_class_t c,
                         input logic redir);
        dec_valid    = v;
        dec_rs1_id   = rs1;
        dec_use_rs1  = u1;
        dec_rs2_id   = rs2;
        dec_use_rs2  = u2;
        dec_early    = early;
        dec_rd_id    = rd;
        dec_wr_en    = wr;
        dec_class    = c;
        dec_redirect = redir;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, FU_ALU, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        instr_mem_resp = 1'b1;
        data_mem_resp  = 1'b1;
        mem_access     = 1'b0;
        div_done       = 1'b0;
        div_rd_id      = 5'd0;
        idle();
        chk("reset_ctl", 32'(ctl), 32'(NORM));
        chk("reset_div_busy", 32'(div_busy), 32'd0);
        chk("reset_stall_cnt", stall_cycles, 32'd0);
        chk("reset_freeze_cnt", freeze_cycles, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // ALU x5 then early consumer: one stall
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, FU_ALU, 1'b0);
        chk("alu_issue", 32'(ctl), 32'(NORM));
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, FU_ALU, 1'b0);
        chk("alu_early_stall", 32'(ctl), 32'(STALL));
        tick();
        chk("alu_early_go", 32'(ctl), 32'(NORM));
        tick();

        // LOAD x7 then normal consumer via rs2: one stall
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, FU_LOAD, 1'b0);
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd8, 1'b1, FU_ALU, 1'b0);
        chk("load_norm_stall", 32'(ctl), 32'(STALL));
        tick();
        chk("load_norm_go", 32'(ctl), 32'(NORM));
        tick();

        // LOAD x7 then early consumer: two stalls
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, FU_LOAD, 1'b0);
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, FU_ALU, 1'b0);
        chk("load_early_stall1", 32'(ctl), 32'(STALL));
        tick();
        chk("load_early_stall2", 32'(ctl), 32'(STALL));
        tick();
        chk("load_early_go", 32'(ctl), 32'(NORM));
        tick();

        // LOAD to x0 never creates a hazard
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, FU_LOAD, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, FU_ALU, 1'b0);
        chk("load_x0_no_stall", 32'(ctl), 32'(NORM));
        tick();

        // MUL x3, early consumer: three stalls
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, FU_MUL, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, FU_ALU, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mul_early_stall%0d", i), 32'(ctl), 32'(STALL));
            tick();
        end
        chk("mul_early_go", 32'(ctl), 32'(NORM));
        tick();

        // MUL x3, normal consumer: two stalls
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, FU_MUL, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, FU_ALU, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mul_norm_stall%0d", i), 32'(ctl), 32'(STALL));
            tick();
        end
        chk("mul_norm_go", 32'(ctl), 32'(NORM));
        tick();
        idle();
        chk("stall_cnt_after_mul", stall_cycles, 32'd9);

        // DIV x9, consumer waits for div_done and issues the cycle after
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, FU_DIV, 1'b0);
        chk("div_issue", 32'(ctl), 32'(NORM));
        tick();
        chk("div_busy_set", 32'(div_busy), 32'd1);
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, FU_ALU, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("div_dep_stall%0d", i), 32'(ctl), 32'(STALL));
            tick();
        end
        div_done  = 1'b1;
        div_rd_id = 5'd9;
        #1;
        chk("div_done_cycle_stall", 32'(ctl), 32'(STALL));
        tick();
        div_done = 1'b0;
        #1;
        chk("div_dep_go", 32'(ctl), 32'(NORM));
        chk("div_busy_clear", 32'(div_busy), 32'd0);
        tick();

        // second divide while busy stalls; WAW on pending rd stalls
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, FU_DIV, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, FU_DIV, 1'b0);
        chk("div_struct_stall", 32'(ctl), 32'(STALL));
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, FU_ALU, 1'b0);
        chk("div_waw_stall", 32'(ctl), 32'(STALL));
        tick();
        idle();
        div_done  = 1'b1;
        div_rd_id = 5'd10;
        tick();
        div_done = 1'b0;
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, FU_ALU, 1'b0);
        chk("waw_after_done_go", 32'(ctl), 32'(NORM));
        tick();

        // Freeze for 4 cycles right after lw x4; entry must still read 2 afterwards
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, FU_LOAD, 1'b0);
        tick();
        idle();
        mem_access    = 1'b1;
        data_mem_resp = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("freeze_ctl%0d", i), 32'(ctl), 32'(FRZ));
            tick();
        end
        mem_access    = 1'b0;
        data_mem_resp = 1'b1;
        drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, FU_ALU, 1'b0);
        chk("post_freeze_stall", 32'(ctl), 32'(STALL));
        tick();
        chk("post_freeze_go", 32'(ctl), 32'(NORM));
        chk("freeze_cnt", freeze_cycles, 32'd4);
        tick();

        // hazard suppresses redirect
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, FU_ALU, 1'b0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, FU_ALU, 1'b1);
        chk("hazard_over_redirect", 32'(ctl), 32'(STALL));
        tick();
        chk("redirect_alone", 32'(ctl), 32'(REDIR));
        tick();
        instr_mem_resp = 1'b0;
        #1;
        chk("redirect_plus_imiss", 32'(ctl), 32'(IMISS));
        idle();
        chk("imiss_alone", 32'(ctl), 32'(IMISS));
        tick();
        instr_mem_resp = 1'b1;
        #1;
        chk("stall_cnt_total", stall_cycles, 32'd17);

        // asynchronous reset during a pending divide
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, FU_DIV, 1'b0);
        tick();
        drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, FU_ALU, 1'b0);
        chk("pre_reset_stall", 32'(ctl), 32'(STALL));
        rst = 1'b0;
        #1;
        chk("reset_mid_div_busy", 32'(div_busy), 32'd0);
        chk("reset_mid_div_ctl", 32'(ctl), 32'(NORM));
        chk("reset_mid_div_stall_cnt", stall_cycles, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("after_reset_go", 32'(ctl), 32'(NORM));
        tick();
        idle();
        div_done  = 1'b1;
        div_rd_id = 5'd12;
        #1;
        chk("late_div_done_ctl", 32'(ctl), 32'(NORM));
        tick();
        div_done = 1'b0;
        #1;
        chk("late_div_done_busy", 32'(div_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
